// File: rtl/ifu_inst_buf.sv
// Instruction buffer between the IFU and the IDU.
// Holds {pc, inst} pairs in a small circular FIFO. There is a valid/ready
// handshake on each side and a one-cycle flush for wrong-path discard.
// Both handshake outputs come from the registered occupancy only, so
// there is no combinational path from i_valid/i_ready to o_ready/o_valid.
module ifu_inst_buf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_inst,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic [PTR_WIDTH:0]    o_count
);

  localparam int ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  // Pointer wrap relies on natural modulo arithmetic.
  initial begin : param_check
  end

  logic [ENTRY_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_WIDTH:0]   count_reg,  count_next;

  logic                 push;
  logic                 pop;
  logic                 push_commit;
  logic [DEPTH-1:0]     wr_en;
  logic [ENTRY_WIDTH-1:0] head_entry;

  assign o_ready = (count_reg != FULL_COUNT);
  assign o_valid = (count_reg != '0);
  assign o_count = count_reg;

  // Handshake events. A flush discards the entry offered in the same
  // cycle, but the upstream side still sees the transfer complete.
  assign push        = i_valid & o_ready;
  assign pop         = o_valid & i_ready;
  assign push_commit = push & ~i_flush;

  // One-hot write enable per storage slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push_commit & (wr_ptr_reg == PTR_WIDTH'(gi));
  end

  // Storage write. The payload is only sampled on a real push, so X on
  // i_pc/i_inst while i_valid is low never reaches the array.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        mem[i] <= {i_pc, i_inst};
      end
    end
  end

  // Head data is zeroed when empty so stale contents are never visible.
  assign head_entry = mem[rd_ptr_reg];
  assign o_pc   = o_valid ? head_entry[ENTRY_WIDTH-1:DATA_WIDTH] : '0;
  assign o_inst = o_valid ? head_entry[DATA_WIDTH-1:0]           : '0;

  // Next-state for pointers and occupancy; flush overrides push/pop.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + (PTR_WIDTH + 1)'(1);
        2'b01:   count_next = count_reg - (PTR_WIDTH + 1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: tb/tb_ifu_inst_buf.sv
// Directed self-checking bench for ifu_inst_buf (DEPTH=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ifu_inst_buf;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          valid;
  logic          ready_out;
  logic [AW-1:0] pc;
  logic [DW-1:0] inst;
  logic          valid_out;
  logic          ready;
  logic [AW-1:0] pc_out;
  logic [DW-1:0] inst_out;
  logic [2:0]    count_out;

  int errors = 0;
  int checks = 0;

  ifu_inst_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .i_valid (valid),
    .o_ready (ready_out),
    .i_pc    (pc),
    .i_inst  (inst),
    .o_valid (valid_out),
    .i_ready (ready),
    .o_pc    (pc_out),
    .o_inst  (inst_out),
    .o_count (count_out)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b0; pc = 'x; inst = 'x;
    cyc();
    rst = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_out); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst_out); end
    $display("reset: valid=%b ready=%b count=%0d", valid_out, ready_out, count_out);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; ready = 1'b0;
      pc = 32'h8000_0000 + 32'(4 * i); inst = 32'h0000_1000 + 32'(i);
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got=%b exp=1", i, ready_out); end
      cyc();
      $display("fill push pc=%h count=%0d", pc, count_out);
      checks++; if (count_out !== 3'(i + 1)) begin errors++; $display("FAIL fill_count_%0d got=%0d exp=%0d", i, count_out, i + 1); end
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL fill_valid_%0d got=%b exp=1", i, valid_out); end
      checks++; if (pc_out !== 32'h8000_0000) begin errors++; $display("FAIL fill_head_%0d got=%h exp=80000000", i, pc_out); end
    end
    valid = 1'b0; pc = 'x; inst = 'x;
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", ready_out); end
  endtask

  task automatic test_drain();
    ready = 1'b1; valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL drain_valid_%0d got=%b exp=1", i, valid_out); end
      checks++; if (pc_out !== 32'h8000_0000 + 32'(4 * i)) begin errors++; $display("FAIL drain_pc_%0d got=%h exp=%h", i, pc_out, 32'h8000_0000 + 32'(4 * i)); end
      checks++; if (inst_out !== 32'h0000_1000 + 32'(i)) begin errors++; $display("FAIL drain_inst_%0d got=%h exp=%h", i, inst_out, 32'h0000_1000 + 32'(i)); end
      $display("drain pop pc=%h", pc_out);
      cyc();
    end
    ready = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got=%b exp=0", valid_out); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL drain_empty_pc got=%h exp=0", pc_out); end
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL drain_empty_count got=%0d exp=0", count_out); end
  endtask

  task automatic test_stream_wrap();
    for (int k = 0; k < 10; k++) begin
      valid = 1'b1; ready = 1'b1;
      pc = 32'h8000_0000 + 32'(4 * k); inst = 32'h0000_2000 + 32'(k);
      if (k == 0) begin
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL stream_start_valid got=%b exp=0", valid_out); end
      end else begin
        checks++; if (count_out !== 3'd1) begin errors++; $display("FAIL stream_count_%0d got=%0d exp=1", k, count_out); end
        checks++; if (pc_out !== 32'h8000_0000 + 32'(4 * (k - 1))) begin errors++; $display("FAIL stream_pc_%0d got=%h exp=%h", k, pc_out, 32'h8000_0000 + 32'(4 * (k - 1))); end
        checks++; if (inst_out !== 32'h0000_2000 + 32'(k - 1)) begin errors++; $display("FAIL stream_inst_%0d got=%h exp=%h", k, inst_out, 32'h0000_2000 + 32'(k - 1)); end
      end
      $display("stream push pc=%h head=%h", pc, pc_out);
      cyc();
    end
    valid = 1'b0; pc = 'x; inst = 'x;
    checks++; if (pc_out !== 32'h8000_0024) begin errors++; $display("FAIL stream_last_pc got=%h exp=80000024", pc_out); end
    cyc();
    ready = 1'b0;
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL stream_end_count got=%0d exp=0", count_out); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; ready = 1'b0; pc = 32'hA000_0000 + 32'(4 * i); inst = 32'(i);
      cyc();
    end
    valid = 1'b1; ready = 1'b1; pc = 32'h8000_0010; inst = 32'h0000_0010;
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL fullpop_ready got=%b exp=0", ready_out); end
    checks++; if (pc_out !== 32'hA000_0000) begin errors++; $display("FAIL fullpop_head got=%h exp=a0000000", pc_out); end
    cyc();
    $display("fullpop pop+refused push count=%0d", count_out);
    checks++; if (count_out !== 3'd3) begin errors++; $display("FAIL fullpop_count got=%0d exp=3", count_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL fullpop_ready_next got=%b exp=1", ready_out); end
    ready = 1'b0;
    cyc();
    valid = 1'b0; pc = 'x; inst = 'x;
    checks++; if (count_out !== 3'd4) begin errors++; $display("FAIL fullpop_retry_count got=%0d exp=4", count_out); end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_pc;
      exp_pc = (i < 3) ? 32'hA000_0004 + 32'(4 * i) : 32'h8000_0010;
      checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL fullpop_drain_%0d got=%h exp=%h", i, pc_out, exp_pc); end
      $display("fullpop drain pc=%h", pc_out);
      cyc();
    end
    ready = 1'b0;
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL fullpop_end_count got=%0d exp=0", count_out); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; ready = 1'b0; pc = 32'hB000_0000 + 32'(4 * i); inst = 32'(i);
      cyc();
    end
    flush = 1'b1; valid = 1'b1; pc = 32'h9000_0000; inst = 32'h0000_0009;
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", ready_out); end
    cyc();
    flush = 1'b0; valid = 1'b0; pc = 'x; inst = 'x;
    $display("flush count=%0d valid=%b", count_out, valid_out);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", valid_out); end
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL flush_ready_next got=%b exp=1", ready_out); end
    valid = 1'b1; pc = 32'h9000_0000; inst = 32'h0000_0009;
    cyc();
    valid = 1'b0; pc = 'x; inst = 'x;
    checks++; if (pc_out !== 32'h9000_0000) begin errors++; $display("FAIL flush_head got=%h exp=90000000", pc_out); end
    checks++; if (inst_out !== 32'h0000_0009) begin errors++; $display("FAIL flush_head_inst got=%h exp=9", inst_out); end
    checks++; if (count_out !== 3'd1) begin errors++; $display("FAIL flush_repush_count got=%0d exp=1", count_out); end
    ready = 1'b1;
    cyc();
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1; ready = 1'b0; pc = 32'hC000_0000 + 32'(4 * i); inst = 32'(i);
      cyc();
    end
    rst = 1'b1; valid = 1'b1; pc = 32'hC000_0008;
    cyc();
    rst = 1'b0; valid = 1'b0; pc = 'x; inst = 'x;
    $display("midreset count=%0d valid=%b", count_out, valid_out);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", valid_out); end
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", count_out); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL midrst_pc got=%h exp=0", pc_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", ready_out); end
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1; pc = 32'hD000_0000 + 32'(4 * i); inst = 32'h0000_D000 + 32'(i);
      cyc();
    end
    valid = 1'b0; pc = 'x; inst = 'x;
    checks++; if (count_out !== 3'd2) begin errors++; $display("FAIL midrst_new_count got=%0d exp=2", count_out); end
    ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (pc_out !== 32'hD000_0000 + 32'(4 * i)) begin errors++; $display("FAIL midrst_drain_%0d got=%h exp=%h", i, pc_out, 32'hD000_0000 + 32'(4 * i)); end
      $display("midreset drain pc=%h", pc_out);
      cyc();
    end
    ready = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL midrst_end_valid got=%b exp=0", valid_out); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream_wrap();
    test_full_pop();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
